// File: rtl/mult_approx_pkg.sv
// Shared definitions for the approximate-multiplier library: tile geometry,
// per-tile approximation modes and the truncation mask.
package mult_approx_pkg;

  localparam int TILE_W = 4;
  localparam int PROD_W = 2 * TILE_W;

  // Low two product bits are dropped in TRUNC mode
  localparam logic [PROD_W-1:0] TRUNC_MASK = 8'hFC;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_ORPP  = 2'b10,
    MODE_OFF   = 2'b11
  } tile_mode_e;

endpackage

// File: rtl/approx_tile_4x4.sv
// Combinational 4x4 tile multiplier with a runtime-selectable approximation.
module approx_tile_4x4
  import mult_approx_pkg::*;
(
  input  logic [TILE_W-1:0] x,
  input  logic [TILE_W-1:0] y,
  input  logic [1:0]        mode,
  output logic [PROD_W-1:0] p
);

  tile_mode_e          md;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   orpp;

  assign md = tile_mode_e'(mode);

  // Exact product and the OR-of-partial-products approximation
  always_comb begin
    prod = PROD_W'(x) * PROD_W'(y);
    orpp = '0;
    for (int unsigned m = 0; m < TILE_W; m++) begin
      if (y[m]) orpp = orpp | (PROD_W'(x) << m);
    end
  end

  // Select the tile result according to its mode
  always_comb begin
    p = '0;
    unique case (md)
      MODE_EXACT: p = prod;
      MODE_TRUNC: p = prod & TRUNC_MASK;
      MODE_ORPP:  p = orpp;
      MODE_OFF:   p = '0;
      default:    p = '0;
    endcase
  end

endmodule

// File: rtl/mult_nxn_approx_pipe.sv
// Pipelined NxN unsigned approximate multiplier with an exact shadow product,
// absolute error output and a saturating error counter. Two register stages,
// valid/ready handshake on both sides.
module mult_nxn_approx_pipe
  import mult_approx_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0]                    a,
  input  logic [N-1:0]                    b,
  input  logic [2*(N/TILE_W)*(N/TILE_W)-1:0] tile_mode,
  input  logic                            acc_or,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*N-1:0]                  r,
  output logic [2*N-1:0]                  r_exact,
  output logic [2*N-1:0]                  err,
  output logic [CNT_W-1:0]                err_cnt,
  input  logic                            cnt_clr
);

  localparam int T  = N / TILE_W;
  localparam int NT = T * T;
  localparam int RW = 2 * N;

  // Tile outputs (combinational from the input operands)
  logic [PROD_W-1:0] tp [NT];

  // Stage 1 state
  logic              s1_v;
  logic [PROD_W-1:0] s1_p [NT];
  logic [RW-1:0]     s1_exact;
  logic              s1_or;

  // Stage 2 occupancy
  logic              s2_v;
  logic              s2_adv;

  // Merge and error path
  logic [RW-1:0]     m_sum;
  logic [RW-1:0]     m_or;
  logic [RW-1:0]     m_r;
  logic [RW-1:0]     m_err;

  logic [RW-1:0]     a_ext;
  logic [RW-1:0]     b_ext;

  assign a_ext = RW'(a);
  assign b_ext = RW'(b);

  for (genvar i = 0; i < T; i++) begin : g_row
    for (genvar j = 0; j < T; j++) begin : g_col
      approx_tile_4x4 u_tile (
        .x    (a[TILE_W*i +: TILE_W]),
        .y    (b[TILE_W*j +: TILE_W]),
        .mode (tile_mode[2*(i*T+j) +: 2]),
        .p    (tp[i*T+j])
      );
    end
  end

  // A stage advances when its successor is empty or draining this cycle
  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;

  // Stage 1: capture tile products, exact product and merge selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_p     <= '{default: '0};
      s1_exact <= '0;
      s1_or    <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_p     <= tp;
        s1_exact <= a_ext * b_ext;
        s1_or    <= acc_or;
      end
    end
  end

  // Merge shifted tile products by add or OR, then form |exact - approx|
  always_comb begin
    m_sum = '0;
    m_or  = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      m_sum = m_sum + (RW'(s1_p[k]) << (TILE_W * ((k / T) + (k % T))));
      m_or  = m_or  | (RW'(s1_p[k]) << (TILE_W * ((k / T) + (k % T))));
    end
    m_r   = s1_or ? m_or : m_sum;
    m_err = (s1_exact >= m_r) ? (s1_exact - m_r) : (m_r - s1_exact);
  end

  // Stage 2: registered outputs, held stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      r       <= '0;
      r_exact <= '0;
      err     <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        r       <= m_r;
        r_exact <= s1_exact;
        err     <= m_err;
      end
    end
  end

  // Saturating count of delivered results with nonzero error; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (s2_v && out_ready && (err != '0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_nxn_approx_pipe.sv
// Scoreboard bench for mult_nxn_approx_pipe (N=16, narrow counter so
// saturation is reachable quickly).
module tb_mult_nxn_approx_pipe;

  localparam int N     = 16;
  localparam int CNT_W = 8;
  localparam int T     = N / 4;
  localparam int RW    = 2 * N;
  localparam int MW    = 2 * T * T;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic [MW-1:0]    tile_mode = '0;
  logic             acc_or = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [RW-1:0]    r;
  logic [RW-1:0]    r_exact;
  logic [RW-1:0]    err;
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr = 1'b0;

  mult_nxn_approx_pipe #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tile_mode (tile_mode),
    .acc_or    (acc_or),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .r_exact   (r_exact),
    .err       (err),
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] r;
    logic [RW-1:0] rx;
    logic [RW-1:0] e;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_deliv = 0;
  int   clr_hit = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: per-tile arithmetic straight from the mode definitions
  function automatic exp_t model(input logic [N-1:0] a_, input logic [N-1:0] b_,
                                 input logic [MW-1:0] md, input logic orr);
    exp_t o;
    longint unsigned s = 0, ov = 0, p, x, y, aa, bb, ex, rr;
    for (int i = 0; i < T; i++) begin
      for (int j = 0; j < T; j++) begin
        x = (longint'(a_) >> (4 * i)) & 15;
        y = (longint'(b_) >> (4 * j)) & 15;
        case (md[2*(i*T+j) +: 2])
          2'd0: p = x * y;
          2'd1: p = (x * y) & 'hFC;
          2'd2: begin
            p = 0;
            for (int m = 0; m < 4; m++) if (((y >> m) & 1) == 1) p = p | (x << m);
          end
          default: p = 0;
        endcase
        s  = s + (p << (4 * (i + j)));
        ov = ov | (p << (4 * (i + j)));
      end
    end
    aa = a_;
    bb = b_;
    ex = aa * bb;
    rr = orr ? ov : s;
    o.r  = RW'(rr);
    o.rx = RW'(ex);
    o.e  = RW'((ex >= rr) ? (ex - rr) : (rr - ex));
    return o;
  endfunction

  // Monitor: pops on every deliver, tracks err_cnt and stall stability
  bit            stalled = 1'b0;
  logic [RW-1:0] hr, hrx, he;
  int            mcnt = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   dlv, nz;
    if (rst) begin
      sb.delete();
      mcnt    = 0;
      stalled = 1'b0;
    end else begin
      nz  = 1'b0;
      dlv = out_valid && out_ready;
      chk("err_cnt", 64'(err_cnt), 64'(mcnt));
      if (stalled) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_r", 64'(r), 64'(hr));
        chk("hold_rx", 64'(r_exact), 64'(hrx));
        chk("hold_err", 64'(err), 64'(he));
      end
      if (dlv) begin
        n_deliv++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got r=%0h expected no result", r);
        end else begin
          e = sb.pop_front();
          chk("r", 64'(r), 64'(e.r));
          chk("r_exact", 64'(r_exact), 64'(e.rx));
          chk("err", 64'(err), 64'(e.e));
          nz = (e.e != 0);
        end
      end
      if (cnt_clr && dlv && nz) clr_hit++;
      if (cnt_clr) mcnt = 0;
      else if (dlv && nz && mcnt != CMAX) mcnt++;
      stalled = out_valid && !out_ready;
      hr  = r;
      hrx = r_exact;
      he  = err;
    end
  end

  // Drive one beat (called at posedge+1); held until accepted
  task automatic send(input logic [N-1:0] a_, input logic [N-1:0] b_,
                      input logic [MW-1:0] md, input logic orr, input exp_t e);
    int unsigned w = 0;
    bit ok = 1'b0;
    a = a_; b = b_; tile_mode = md; acc_or = orr; in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) sb.push_back(e);
      #1;
      w++;
      if (!ok && w > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", w);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit allow_clr);
    logic [N-1:0]  ra, rb;
    logic [MW-1:0] rm;
    logic          ro;
    ra = N'($urandom());
    rb = N'($urandom());
    if ($urandom_range(0, 19) == 0) ra = '1;
    if ($urandom_range(0, 19) == 0) rb = '0;
    rm = MW'($urandom());
    ro = 1'($urandom());
    cnt_clr = allow_clr && ($urandom_range(0, 29) == 0);
    send(ra, rb, rm, ro, model(ra, rb, rm, ro));
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   d0;
    bit   saw_full;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed products (upper nibbles zero, so N=8 values apply)
    e = '{r: 32'hFE01, rx: 32'hFE01, e: 32'h0};
    send(16'h00FF, 16'h00FF, '0, 1'b0, e);
    drain();
    chk("t1_err_cnt", 64'(err_cnt), 64'd0);
    e = '{r: 32'hEFF1, rx: 32'hFE01, e: 32'h0E10};
    send(16'h00FF, 16'h00FF, '0, 1'b1, e);
    drain();
    chk("t2_err_cnt", 64'(err_cnt), 64'd1);
    e = '{r: 32'h8, rx: 32'h9, e: 32'h1};
    send(16'h3, 16'h3, 32'h1, 1'b0, e);
    e = '{r: 32'h7, rx: 32'h9, e: 32'h2};
    send(16'h3, 16'h3, 32'h2, 1'b0, e);
    e = '{r: 32'h0, rx: 32'h9, e: 32'h9};
    send(16'h3, 16'h3, 32'h3, 1'b0, e);
    drain();
    chk("t3_err_cnt", 64'(err_cnt), 64'd4);

    // Back-to-back beats with a 4-cycle output stall
    d0 = n_deliv;
    saw_full = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_rand(1'b0);
      end
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (!in_ready && !out_ready) saw_full = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_in_ready_fell", 64'(saw_full), 64'd1);
    chk("t4_deliver_count", 64'(n_deliv - d0), 64'd8);

    // Async reset with beats in flight, then latency after reset
    send_rand(1'b0);
    send_rand(1'b0);
    chk("t5_pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("t5_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send_rand(1'b0);
    chk("t5_lat_t1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t5_lat_t2", 64'(out_valid), 64'd1);
    drain();
    chk("t5_flushed", 64'(sb.size()), 64'd0);

    // Random traffic with random backpressure
    fork
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 99) < 70);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 3000; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rand(1'b0);
        end
        drain();
        chk("t6_saturated", 64'(err_cnt), 64'(CMAX));
        for (int k = 0; k < 7000; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rand(1'b1);
        end
        drain();
        done = 1'b1;
      end
    join
    chk("t6_clr_with_err_deliver", 64'(clr_hit > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
